piso_stream: RTL and testbench
==============================

// Module: piso_stream
// PURPOSE
//   Parametrised parallel-in/serial-out shifter with valid/ready handshakes on both sides.
//   Accepts WIDTH-bit words and emits them one bit per handshake. Bit order is selectable per word.
//   A one-word holding buffer gives back-to-back words with no idle cycle between them.
//   Sits between a word-oriented producer and a bit-serial link such as a UART or SPI TX datapath.
// PARAMETERS
//   WIDTH   8  bits per word; WIDTH >= 2
//   CNT_W   $clog2(WIDTH)  bit-counter width; derived, do not override
// PORTS
//   clk         in   1      rising-edge clock; the only clock
//   reset_n     in   1      reset, synchronous, active-low
//   load_valid  in   1      producer offers par_in/msb_first
//   load_ready  out  1      block can accept a word this cycle
//   par_in      in   WIDTH  parallel word
//   msb_first   in   1      1 = send bit WIDTH-1 first; 0 = send bit 0 first; captured with the word
//   ser_valid   out  1      ser_data holds a valid bit
//   ser_ready   in   1      consumer takes ser_data this cycle
//   ser_data    out  1      current serial bit
//   ser_last    out  1      ser_data is the final bit of its word
//   busy        out  1      shift register or buffer is occupied
// BEHAVIOUR
//   Reset (reset_n=0 at posedge): shreg=0, buf=0, cnt=0, state=IDLE, buf_valid=0, ser_valid=0,
//     ser_data=0, ser_last=0, busy=0. load_ready=0 while reset_n=0, and 1 on the first cycle after.
//   Reset mid-word aborts the word immediately. Partial words are never resumed.
//   Handshake: a transfer occurs when valid&&ready at the posedge. load_ready = reset_n & ~buf_valid.
//   FSM states: IDLE, SHIFT.
//     IDLE: on a load transfer, shreg<=par_in, mode<=msb_first, cnt<=0 -> SHIFT.
//     SHIFT: on a ser transfer with cnt<WIDTH-1, shift shreg one place and cnt<=cnt+1.
//       LSB mode shifts right (0 into MSB). MSB mode shifts left (0 into LSB).
//     SHIFT: on a ser transfer with cnt==WIDTH-1 (last bit):
//       if buf_valid: shreg<=buf, mode<=buf_mode, cnt<=0, buf_valid<=0, stay in SHIFT (no gap);
//       else if load transfer in the same cycle: load par_in directly, stay in SHIFT;
//       else go to IDLE.
//     SHIFT: a load transfer that does not go directly to shreg writes buf/buf_mode and sets buf_valid.
//   Outputs (combinational from registers):
//     ser_valid = (state==SHIFT)
//     ser_data  = mode ? shreg[WIDTH-1] : shreg[0]
//     ser_last  = ser_valid & (cnt==WIDTH-1)
//     busy      = ser_valid | buf_valid
//   Latency: word accepted at edge N -> first bit valid in cycle N+1.
//     Full throughput is one bit per cycle when ser_ready=1.
//   Backpressure: while ser_ready=0, shreg, cnt, ser_data and ser_last hold. The buffer still fills once.
//   Buffer full and last bit pending: buffer drains into shreg on that edge, so load_ready rises the next cycle.
//   cnt wraps only by reload to 0; it never counts past WIDTH-1.
//   No combinational path from ser_ready to load_ready.
// STRUCTURE
//   Package piso_pkg: typedef enum logic {IDLE, SHIFT} piso_state_t; function shift_next(word, mode).
//   Single module. No sub-module: the holding buffer is one register plus a flag and is kept inline.
// TESTING
//   1 WIDTH=8, ser_ready=1, load 8'hC1 with msb_first=0 -> ser_data 1,0,0,0,0,0,1,1 on cycles 1..8;
//     ser_last only on cycle 8; ser_valid=0 in cycle 9.
//   2 Same word with msb_first=1 -> ser_data 1,1,0,0,0,0,0,1.
//   3 Load 8'hFF then 8'h00 back-to-back (second word buffered) -> 16 consecutive valid cycles;
//     ser_last in cycles 8 and 16; load_ready=0 while the buffer is occupied.
//   4 Load 8'hC1 (LSB first), hold ser_ready=0 in cycles 3-5 -> ser_data stays 0 and cnt stays 2;
//     the sequence resumes unchanged and ser_last appears at cycle 11.
//   5 Mode mix: word A=8'h01 LSB first, buffered word B=8'h01 MSB first ->
//     A gives 1 then seven 0s; B gives seven 0s then 1.
//   6 Assert reset_n=0 during bit 4 of a word with a buffered word ->
//     the next cycle shows ser_valid=0, busy=0, load_ready=1; a fresh load then serialises correctly.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and the shift helper for the parallel-in/serial-out streamer.
package piso_pkg;

    // Upper bound on the word width that shift_next can handle.
    localparam int unsigned PISO_MAX_W = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    // Width-agnostic one-place shift. The caller zero-extends its word, so the
    // right shift brings a 0 into the word's MSB. Truncation on return drops
    // whatever the left shift pushed above the word.
    function automatic logic [PISO_MAX_W-1:0] shift_next(
        input logic [PISO_MAX_W-1:0] word,
        input logic                  mode
    );
        return mode ? (word << 1) : (word >> 1);
    endfunction

endpackage

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready on both sides and a one-word
// holding buffer, so consecutive words stream out with no idle cycle between them.
module piso_stream
    import piso_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] par_in,
    input  logic             msb_first,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_data,
    output logic             ser_last,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    piso_state_t      r_state;
    logic [WIDTH-1:0] r_shreg;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_buf;
    logic             r_buf_mode;
    logic             r_buf_valid;

    logic             w_load_fire;
    logic             w_ser_fire;
    logic             w_last;
    logic             w_direct;
    logic [WIDTH-1:0] w_shifted;

    assign w_load_fire = load_valid & load_ready;
    assign w_ser_fire  = (r_state == SHIFT) & ser_ready;
    assign w_last      = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_shifted   = WIDTH'(shift_next(PISO_MAX_W'(r_shreg), r_mode));

    // An empty buffer at the last bit lets a concurrent load go straight to shreg.
    assign w_direct    = w_ser_fire & w_last & ~r_buf_valid;

    // load_ready depends only on registers and reset, never on ser_ready.
    assign load_ready = reset_n & ~r_buf_valid;
    assign ser_valid  = (r_state == SHIFT);
    assign ser_data   = r_mode ? r_shreg[WIDTH-1] : r_shreg[0];
    assign ser_last   = ser_valid & w_last;
    assign busy       = ser_valid | r_buf_valid;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_shreg     <= '0;
            r_mode      <= 1'b0;
            r_cnt       <= '0;
            r_buf       <= '0;
            r_buf_mode  <= 1'b0;
            r_buf_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load_fire) begin
                        r_shreg <= par_in;
                        r_mode  <= msb_first;
                        r_cnt   <= '0;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_ser_fire && !w_last) begin
                        r_shreg <= w_shifted;
                        r_cnt   <= r_cnt + CNT_W'(1);
                    end else if (w_ser_fire && w_last) begin
                        if (r_buf_valid) begin
                            r_shreg     <= r_buf;
                            r_mode      <= r_buf_mode;
                            r_cnt       <= '0;
                            r_buf_valid <= 1'b0;
                        end else if (w_load_fire) begin
                            r_shreg <= par_in;
                            r_mode  <= msb_first;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                    // Any other accepted word while shifting parks in the buffer.
                    if (w_load_fire && !w_direct) begin
                        r_buf       <= par_in;
                        r_buf_mode  <= msb_first;
                        r_buf_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_stream.sv
// Directed bench for piso_stream: bit order, back-to-back buffering, backpressure and mid-word reset.
module tb_piso_stream;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] par_in;
    logic             msb_first;
    logic             ser_valid;
    logic             ser_ready;
    logic             ser_data;
    logic             ser_last;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Hand-computed serial sequences, cycle 1 first.
    bit e1  [8]  = '{1, 0, 0, 0, 0, 0, 1, 1};
    bit e2  [8]  = '{1, 1, 0, 0, 0, 0, 0, 1};
    bit e3  [16] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    bit e4  [11] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    bit e5  [16] = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
    bit e6  [8]  = '{1, 0, 1, 0, 0, 1, 0, 1};

    piso_stream #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .par_in     (par_in),
        .msb_first  (msb_first),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .ser_data   (ser_data),
        .ser_last   (ser_last),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns at the falling edge where outputs are stable.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_bit(input string tag, input bit d, input bit last);
        chk({tag, ".valid"}, 16'(ser_valid), 16'd1);
        chk({tag, ".data"},  16'(ser_data),  16'(d));
        chk({tag, ".last"},  16'(ser_last),  16'(last));
    endtask

    task automatic run_word(input string tag, input logic [WIDTH-1:0] w, input logic m,
                            input bit e [8]);
        load_valid = 1'b1;
        par_in     = w;
        msb_first  = m;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk_bit($sformatf("%s.c%0d", tag, c + 1), e[c], c == 7);
            tick();
        end
        chk({tag, ".idle_valid"}, 16'(ser_valid), 16'd0);
        chk({tag, ".idle_busy"},  16'(busy),      16'd0);
    endtask

    task automatic run_pair(input string tag, input logic [WIDTH-1:0] wa, input logic ma,
                            input logic [WIDTH-1:0] wb, input logic mb, input bit e [16]);
        load_valid = 1'b1;
        par_in     = wa;
        msb_first  = ma;
        tick();
        for (int c = 1; c <= 16; c++) begin
            chk_bit($sformatf("%s.c%0d", tag, c), e[c-1], (c == 8) || (c == 16));
            chk($sformatf("%s.c%0d.ready", tag, c), 16'(load_ready),
                16'((c >= 2 && c <= 8) ? 0 : 1));
            chk($sformatf("%s.c%0d.busy", tag, c), 16'(busy), 16'd1);
            if (c == 1) begin
                par_in    = wb;
                msb_first = mb;
            end else begin
                load_valid = 1'b0;
            end
            tick();
        end
        chk({tag, ".idle_valid"}, 16'(ser_valid), 16'd0);
        chk({tag, ".idle_busy"},  16'(busy),      16'd0);
    endtask

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        par_in     = '0;
        msb_first  = 1'b0;
        ser_ready  = 1'b1;
        tick();
        tick();
        chk("rst.valid", 16'(ser_valid),  16'd0);
        chk("rst.data",  16'(ser_data),   16'd0);
        chk("rst.last",  16'(ser_last),   16'd0);
        chk("rst.busy",  16'(busy),       16'd0);
        chk("rst.ready", 16'(load_ready), 16'd0);
        reset_n = 1'b1;
        tick();
        chk("post_rst.ready", 16'(load_ready), 16'd1);

        // LSB-first and MSB-first single words
        run_word("t1", 8'hC1, 1'b0, e1);
        run_word("t2", 8'hC1, 1'b1, e2);

        // Back-to-back words through the buffer
        run_pair("t3", 8'hFF, 1'b0, 8'h00, 1'b0, e3);

        // Backpressure in cycles 3-5
        load_valid = 1'b1;
        par_in     = 8'hC1;
        msb_first  = 1'b0;
        tick();
        load_valid = 1'b0;
        for (int c = 1; c <= 11; c++) begin
            chk_bit($sformatf("t4.c%0d", c), e4[c-1], c == 11);
            ser_ready = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
            tick();
        end
        chk("t4.idle_valid", 16'(ser_valid), 16'd0);

        // Mixed bit order across the buffer
        run_pair("t5", 8'h01, 1'b0, 8'h01, 1'b1, e5);

        // Reset during bit 4 with a word buffered
        load_valid = 1'b1;
        par_in     = 8'hC1;
        msb_first  = 1'b0;
        tick();
        par_in     = 8'h3C;
        msb_first  = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("t6.buffered_ready", 16'(load_ready), 16'd0);
        tick();
        tick();
        tick();
        chk_bit("t6.bit4", 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        chk("t6.rst_ready", 16'(load_ready), 16'd0);
        tick();
        reset_n = 1'b1;
        #1;
        chk("t6.after_valid", 16'(ser_valid),  16'd0);
        chk("t6.after_busy",  16'(busy),       16'd0);
        chk("t6.after_ready", 16'(load_ready), 16'd1);
        chk("t6.after_last",  16'(ser_last),   16'd0);
        @(negedge clk);
        run_word("t6.fresh", 8'hA5, 1'b1, e6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
